// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR pseudo-random generator.
package lfsr_pkg;

   // Mode encodings; any encoding other than FREE/STEP behaves as HOLD.
   localparam logic [1:0] FREE = 2'b00;
   localparam logic [1:0] STEP = 2'b01;
   localparam logic [1:0] HOLD = 2'b10;

   // Divider counter width; a zero-width counter is not legal, so DIV=0 gets one bit.
   function automatic int div_width(input int div);
      return (div > 0) ? $clog2(div + 1) : 1;
   endfunction

endpackage

// File: rtl/lfsr_prng_tick_div.sv
// Free-run period divider: asserts due on the last cycle of each DIV+1 cycle period.
module tick_div
   import lfsr_pkg::*;
#(
   parameter int DIV = 70000000
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clear,
   output logic due
);

   localparam int CW = div_width(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV);

   logic [CW-1:0] cnt;

   // due is combinational here; the top registers everything it produces from it.
   assign due = run && (cnt == LAST);

   // Count only while running; any stop or clear restarts a full period.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (clear || !run || cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/lfsr_prng.sv
// Fibonacci LFSR PRNG with free-run/step/hold modes, load, wrap and advance counting.
module lfsr_prng
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = 8'h1D,
   parameter logic [WIDTH-1:0] SEED  = 8'hB8,
   parameter int               DIV   = 70000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic             step,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             tick,
   output logic             wrap,
   output logic             zero_fix,
   output logic [WIDTH-1:0] adv_cnt
);

   // Reject parameter sets that cannot produce a working sequence.
   generate
      if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
         $fatal(1, "lfsr_prng: WIDTH must be 4..32");
      end
      if (TAPS[0] != 1'b1) begin : g_bad_taps
         $fatal(1, "lfsr_prng: TAPS[0] must be 1");
      end
      if (SEED == '0) begin : g_bad_seed
         $fatal(1, "lfsr_prng: SEED must be nonzero");
      end
   endgenerate

   logic [WIDTH-1:0] state;
   logic [WIDTH-1:0] start;
   logic [WIDTH-1:0] nxt;
   logic             due;
   logic             adv;

   tick_div #(.DIV(DIV)) u_div (
      .clk   (clk),
      .rst   (rst),
      .run   (mode == FREE),
      .clear (load),
      .due   (due)
   );

   // Shift right with parity of tapped bits fed into the MSB.
   assign nxt = {^(state & TAPS), state[WIDTH-1:1]};

   // A load in the same cycle swallows whatever advance was due.
   assign adv = !load && ((mode == FREE && due) || (mode == STEP && step));

   assign out = state;

   // State, start reference, saturating counter and one-cycle status pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= SEED;
         start    <= SEED;
         adv_cnt  <= '0;
         tick     <= 1'b0;
         wrap     <= 1'b0;
         zero_fix <= 1'b0;
      end else begin
         tick     <= 1'b0;
         wrap     <= 1'b0;
         zero_fix <= 1'b0;
         if (load) begin
            adv_cnt <= '0;
            if (load_val == '0) begin
               // All-zero is the LFSR lock-up state; substitute the seed.
               state    <= SEED;
               start    <= SEED;
               zero_fix <= 1'b1;
            end else begin
               state <= load_val;
               start <= load_val;
            end
         end else if (adv) begin
            state <= nxt;
            tick  <= 1'b1;
            wrap  <= (nxt == start);
            if (adv_cnt != {WIDTH{1'b1}})
               adv_cnt <= adv_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lfsr_prng.sv
// Directed bench: one DUT with DIV=3 for timing/load/step, one with DIV=0 for the full cycle.
module tb_lfsr_prng;

   logic       clk;
   logic       rst;
   logic [1:0] mode_a, mode_b;
   logic       step_a, step_b;
   logic       load_a, load_b;
   logic [7:0] load_val_a, load_val_b;
   logic [7:0] out_a, out_b, adv_cnt_a, adv_cnt_b;
   logic       tick_a, tick_b, wrap_a, wrap_b, zero_fix_a, zero_fix_b;

   int n_vec = 0;
   int n_err = 0;

   lfsr_prng #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'hB8), .DIV(3)) dut_a (
      .clk(clk), .rst(rst), .mode(mode_a), .step(step_a), .load(load_a),
      .load_val(load_val_a), .out(out_a), .tick(tick_a), .wrap(wrap_a),
      .zero_fix(zero_fix_a), .adv_cnt(adv_cnt_a)
   );

   lfsr_prng #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'hB8), .DIV(0)) dut_b (
      .clk(clk), .rst(rst), .mode(mode_b), .step(step_b), .load(load_b),
      .load_val(load_val_b), .out(out_b), .tick(tick_b), .wrap(wrap_b),
      .zero_fix(zero_fix_b), .adv_cnt(adv_cnt_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      mode_a = 2'b10; step_a = 1'b0; load_a = 1'b0; load_val_a = 8'h00;
      mode_b = 2'b10; step_b = 1'b0; load_b = 1'b0; load_val_b = 8'h00;

      // Reset state
      #12;
      check("rst_out_a", out_a, 8'hB8);
      check("rst_cnt_a", adv_cnt_a, 8'h00);
      check("rst_tick_a", tick_a, 1'b0);
      check("rst_out_b", out_b, 8'hB8);
      @(posedge clk); #1;
      rst = 1'b1;
      cyc();
      check("rel_out_a", out_a, 8'hB8);
      check("rel_cnt_a", adv_cnt_a, 8'h00);
      check("rel_pulses_a", {tick_a, wrap_a, zero_fix_a}, 3'b000);
      check("rel_out_b", out_b, 8'hB8);

      // DIV=0 free-run: full 255-state cycle, wrap only on the last advance
      mode_b = 2'b00;
      for (int i = 0; i < 255; i++) begin
         cyc();
         check("fr0_tick", tick_b, 1'b1);
         check("fr0_wrap", wrap_b, (i == 254));
         check("fr0_cnt", adv_cnt_b, i + 1);
         if (i == 0) check("fr0_out1", out_b, 8'h5C);
         if (i == 1) check("fr0_out2", out_b, 8'hAE);
         if (i == 2) check("fr0_out3", out_b, 8'h57);
         if (i == 3) check("fr0_out4", out_b, 8'hAB);
      end
      check("fr0_out_wrap", out_b, 8'hB8);
      cyc();
      check("fr0_out_256", out_b, 8'h5C);
      check("fr0_cnt_sat", adv_cnt_b, 8'hFF);
      check("fr0_wrap_off", wrap_b, 1'b0);
      mode_b = 2'b10;

      // DIV=3 free-run: one advance per 4 cycles
      mode_a = 2'b00;
      for (int i = 1; i <= 12; i++) begin
         cyc();
         check("fr3_out", out_a, (i < 4) ? 8'hB8 : (i < 8) ? 8'h5C : (i < 12) ? 8'hAE : 8'h57);
         check("fr3_tick", tick_a, (i % 4 == 0));
         check("fr3_cnt", adv_cnt_a, i / 4);
      end

      // Reset mid-period (divider at 2), checked before any clock edge
      cyc(); cyc();
      #2 rst = 1'b0;
      #1;
      check("mid_rst_out", out_a, 8'hB8);
      check("mid_rst_cnt", adv_cnt_a, 8'h00);
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         cyc();
         check("post_rst_out", out_a, (i < 4) ? 8'hB8 : 8'h5C);
         check("post_rst_tick", tick_a, (i == 4));
      end

      // Load in the cycle an advance is due
      cyc(); cyc(); cyc();
      load_a = 1'b1; load_val_a = 8'h3C;
      cyc();
      load_a = 1'b0;
      check("ld_due_out", out_a, 8'h3C);
      check("ld_due_tick", tick_a, 1'b0);
      check("ld_due_cnt", adv_cnt_a, 8'h00);
      for (int i = 1; i <= 4; i++) begin
         cyc();
         check("ld_fr_out", out_a, (i < 4) ? 8'h3C : 8'h9E);
         check("ld_fr_tick", tick_a, (i == 4));
      end
      check("ld_fr_cnt", adv_cnt_a, 8'h01);

      // Zero load substitutes the seed
      mode_a = 2'b10;
      load_a = 1'b1; load_val_a = 8'h00;
      cyc();
      load_a = 1'b0;
      check("zld_out", out_a, 8'hB8);
      check("zld_fix", zero_fix_a, 1'b1);
      check("zld_cnt", adv_cnt_a, 8'h00);
      cyc();
      check("zld_fix_off", zero_fix_a, 1'b0);
      check("zld_out_hold", out_a, 8'hB8);

      // Step mode: level-sensitive step
      mode_a = 2'b01; step_a = 1'b1;
      cyc();
      check("st_out1", out_a, 8'h5C);
      check("st_tick1", tick_a, 1'b1);
      cyc();
      check("st_out2", out_a, 8'hAE);
      check("st_cnt2", adv_cnt_a, 8'h02);
      step_a = 1'b0;
      cyc();
      check("st_out_idle", out_a, 8'hAE);
      check("st_tick_idle", tick_a, 1'b0);
      cyc();
      check("st_out_idle2", out_a, 8'hAE);

      // Hold modes ignore step
      mode_a = 2'b10; step_a = 1'b1;
      cyc();
      check("hold_out", out_a, 8'hAE);
      check("hold_tick", tick_a, 1'b0);
      mode_a = 2'b11;
      cyc();
      check("hold11_out", out_a, 8'hAE);
      check("hold11_cnt", adv_cnt_a, 8'h02);
      step_a = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/lfsr_prng.md
LFSR_PRNG -- requirements
Module: lfsr_prng

Interface
REQ-001 Parameter WIDTH, default 8: register width, legal range 4..32.
REQ-002 Parameter TAPS, default 8'h1D: feedback mask; TAPS[0] SHALL be 1 (elaboration check).
REQ-003 Parameter SEED, default 8'hB8: reset/recovery state; SHALL be nonzero (elaboration check).
REQ-004 Parameter DIV, default 70000000: free-run advance period is DIV+1 clk cycles; DIV=0 means advance every cycle.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 mode  in  2  00 free-run, 01 step, 10/11 hold.
REQ-008 step  in  1  advance request, honoured in step mode only.
REQ-009 load  in  1  synchronous load request.
REQ-010 load_val  in  WIDTH  value to load.
REQ-011 out  out  WIDTH  current state, registered.
REQ-012 tick  out  1  one-cycle pulse in the cycle after each advance.
REQ-013 wrap  out  1  one-cycle pulse when an advance returns state to start value.
REQ-014 zero_fix  out  1  one-cycle pulse when a zero load was replaced by SEED.
REQ-015 adv_cnt  out  WIDTH  advances since last reset/load, saturating at all-ones.

Function
REQ-016 Advance: next = {^(state & TAPS), state[WIDTH-1:1]} (shift right, feedback into MSB).
REQ-017 Divider counter (width $clog2(DIV+1)) counts 0..DIV in free-run mode; advance occurs in the cycle it equals DIV, then it returns to 0.
REQ-018 In step and hold modes the divider is held at 0; leaving free-run and re-entering restarts a full DIV+1 period.
REQ-019 In step mode each clk cycle with step=1 causes exactly one advance (level, not edge: held step advances every cycle).
REQ-020 In hold mode state is frozen; step is ignored.
REQ-021 Priority per cycle: load > advance; load in the same cycle as a due advance suppresses the advance and its tick.
REQ-022 Load: state <= load_val, start <= load_val, divider <= 0, adv_cnt <= 0; no tick.
REQ-023 load with load_val==0: state and start <= SEED instead, zero_fix pulses next cycle.
REQ-024 start register holds the value of the last load (SEED after reset); wrap pulses together with tick when the advanced state equals start.
REQ-025 adv_cnt increments on each advance, holds at 2^WIDTH-1.
REQ-026 Mode changes take effect the same cycle; no state loss.
REQ-027 All outputs registered; no combinational path input->output.

Reset
REQ-028 On rst low, immediately: state=SEED, start=SEED, divider=0, adv_cnt=0, tick=wrap=zero_fix=0.
REQ-029 Reset asserted mid-period discards the partial divider count; first free-run advance after release occurs DIV+1 cycles later.

Structure
REQ-030 Mode encodings (FREE, STEP, HOLD) SHALL be constants in a shared package lfsr_pkg.
REQ-031 Divider SHALL be a sub-module tick_div (parameter DIV, inputs clk, rst, run, clear; output due).
REQ-032 Target 120-400 RTL lines including tick_div.

Verification (WIDTH=8, TAPS=8'h1D, SEED=8'hB8)
REQ-033 Reset, then release -> out=8'hB8, adv_cnt=0, all pulses 0.
REQ-034 DIV=3, mode=00 -> out B8 ->5C ->AE ->57, one step every 4 cycles, tick pulses after each, adv_cnt 1,2,3.
REQ-035 DIV=0, mode=00, 255 cycles -> wrap pulses exactly once, on the 255th advance, out=8'hB8; adv_cnt=255 and holds.
REQ-036 mode=01, step high 2 cycles then low -> out B8->5C->AE, then stable; in mode=10 step ignored.
REQ-037 load=1, load_val=0 -> out=8'hB8, zero_fix=1 for one cycle; load with advance due same cycle -> no tick, out=load_val.
REQ-038 rst low mid-period (divider=2) -> outputs at reset values without waiting for clk; next advance exactly DIV+1 cycles after release.
